mem_req_arbiter: RTL and testbench

Single-outstanding request arbiter in front of MemCtrl. It shares the byte-serial RAM path between the instruction fetcher (ICache miss), the load unit and the committed-store path. It issues exactly one request at a time to MemCtrl's fetch or LS port, so MemCtrl's internal conflict buffers are never exercised. It routes the completion back to the owner and discards in-flight fetch/load results on rollback.

---
 rtl/mem_req_arbiter_pkg.sv | 14 +
 rtl/mem_arb_prio.sv | 20 ++
 rtl/mem_req_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_req_arbiter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mem_req_arbiter_pkg.sv
// mem_req_arbiter_pkg: shared state encodings, RAM op codes and grant indices for the memory request arbiter.
package mem_req_arbiter_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_WAIT_IF = 2'd1,
    ARB_WAIT_LD = 2'd2,
    ARB_WAIT_ST = 2'd3
  } arb_state_e;
  localparam logic RAM_LOAD  = 1'b0;
  localparam logic RAM_STORE = 1'b1;
  localparam int GNT_IF = 0;
  localparam int GNT_LD = 1;
  localparam int GNT_ST = 2;
endpackage

// File: rtl/mem_arb_prio.sv
// mem_arb_prio: one-hot priority select (store > load > fetch) with starvation override and rollback masking.
module mem_arb_prio
  import mem_req_arbiter_pkg::*;
(
  input  logic       en_i,
  input  logic       rollback_i,
  input  logic       starve_i,
  input  logic       if_v_i,
  input  logic       ld_v_i,
  input  logic       st_v_i,
  output logic [2:0] gnt_o
);
  logic if_ok, fch_win;
  assign if_ok   = if_v_i & ~rollback_i;
  // A starved fetch only overrides when it is actually grantable this cycle.
  assign fch_win = starve_i & if_ok;
  assign gnt_o[GNT_ST] = en_i & st_v_i & ~fch_win;
  assign gnt_o[GNT_LD] = en_i & ld_v_i & ~st_v_i & ~rollback_i & ~fch_win;
  assign gnt_o[GNT_IF] = en_i & if_ok & (fch_win | (~st_v_i & ~ld_v_i));
endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: single-outstanding arbiter sharing MemCtrl between fetch, load and store requesters.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int BLOCK_W      = 128,
  parameter int STARVE_LIMIT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               rollback,
  input  logic               if_req_valid,
  input  logic [ADDR_W-1:0]  if_req_pc,
  output logic               if_req_ready,
  output logic               if_resp_valid,
  output logic [BLOCK_W-1:0] if_resp_block,
  input  logic               ld_req_valid,
  input  logic [ADDR_W-1:0]  ld_req_addr,
  input  logic [2:0]         ld_req_size,
  output logic               ld_req_ready,
  output logic               ld_resp_valid,
  output logic [DATA_W-1:0]  ld_resp_data,
  input  logic               st_req_valid,
  input  logic [ADDR_W-1:0]  st_req_addr,
  input  logic [DATA_W-1:0]  st_req_data,
  input  logic [2:0]         st_req_size,
  output logic               st_req_ready,
  output logic               st_resp_valid,
  output logic               mc_fch_enable,
  output logic [ADDR_W-1:0]  mc_fch_pc,
  output logic               mc_fch_rollback,
  input  logic               mc_fch_finish,
  input  logic [BLOCK_W-1:0] mc_fch_block,
  output logic               mc_ls_enable,
  output logic               mc_ls_sign,
  output logic [ADDR_W-1:0]  mc_ls_addr,
  output logic [2:0]         mc_ls_size,
  output logic [DATA_W-1:0]  mc_ls_store_data,
  input  logic               mc_ls_finish,
  input  logic [DATA_W-1:0]  mc_ls_data
);
  arb_state_e         state_q;
  logic [3:0]         starve_q;
  logic               fch_en_q, ls_en_q, ls_sign_q;
  logic               if_resp_q, ld_resp_q, st_resp_q;
  logic [ADDR_W-1:0]  fch_pc_q, ls_addr_q;
  logic [2:0]         ls_size_q;
  logic [DATA_W-1:0]  ls_wdata_q, ld_data_q;
  logic [BLOCK_W-1:0] if_block_q;
  logic [2:0]         gnt;
  logic               gnt_ls;
  mem_arb_prio u_prio (
    .en_i      (state_q == ARB_IDLE && rdy),
    .rollback_i(rollback),
    .starve_i  (starve_q == 4'(STARVE_LIMIT)),
    .if_v_i    (if_req_valid),
    .ld_v_i    (ld_req_valid),
    .st_v_i    (st_req_valid),
    .gnt_o     (gnt)
  );
  assign gnt_ls           = gnt[GNT_LD] | gnt[GNT_ST];
  assign if_req_ready     = gnt[GNT_IF];
  assign ld_req_ready     = gnt[GNT_LD];
  assign st_req_ready     = gnt[GNT_ST];
  assign mc_fch_rollback  = rollback;
  assign mc_fch_enable    = fch_en_q;
  assign mc_fch_pc        = fch_pc_q;
  assign mc_ls_enable     = ls_en_q;
  assign mc_ls_sign       = ls_sign_q;
  assign mc_ls_addr       = ls_addr_q;
  assign mc_ls_size       = ls_size_q;
  assign mc_ls_store_data = ls_wdata_q;
  assign if_resp_valid    = if_resp_q;
  assign if_resp_block    = if_block_q;
  assign ld_resp_valid    = ld_resp_q;
  assign ld_resp_data     = ld_data_q;
  assign st_resp_valid    = st_resp_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ARB_IDLE;
      starve_q   <= '0;
      fch_en_q   <= 1'b0;
      ls_en_q    <= 1'b0;
      ls_sign_q  <= RAM_LOAD;
      if_resp_q  <= 1'b0;
      ld_resp_q  <= 1'b0;
      st_resp_q  <= 1'b0;
      fch_pc_q   <= '0;
      ls_addr_q  <= '0;
      ls_size_q  <= '0;
      ls_wdata_q <= '0;
      ld_data_q  <= '0;
      if_block_q <= '0;
    end else if (rdy) begin
      fch_en_q  <= gnt[GNT_IF];
      ls_en_q   <= gnt_ls;
      if_resp_q <= 1'b0;
      ld_resp_q <= 1'b0;
      st_resp_q <= 1'b0;
      // Counts LS grants that passed over a waiting fetch; saturates at 15.
      starve_q  <= (!if_req_valid || gnt[GNT_IF]) ? 4'd0 :
                   (gnt_ls && starve_q != 4'hf) ? starve_q + 4'd1 : starve_q;
      case (state_q)
        ARB_IDLE: begin
          if (gnt[GNT_ST]) begin
            state_q    <= ARB_WAIT_ST;
            ls_sign_q  <= RAM_STORE;
            ls_addr_q  <= st_req_addr;
            ls_size_q  <= st_req_size;
            ls_wdata_q <= st_req_data;
          end else if (gnt[GNT_LD]) begin
            state_q   <= ARB_WAIT_LD;
            ls_sign_q <= RAM_LOAD;
            ls_addr_q <= ld_req_addr;
            ls_size_q <= ld_req_size;
          end else if (gnt[GNT_IF]) begin
            state_q  <= ARB_WAIT_IF;
            fch_pc_q <= if_req_pc;
          end
        end
        ARB_WAIT_IF: begin
          if (rollback) begin
            state_q <= ARB_IDLE;
          end else if (mc_fch_finish) begin
            state_q    <= ARB_IDLE;
            if_block_q <= mc_fch_block;
            if_resp_q  <= 1'b1;
          end
        end
        ARB_WAIT_LD: begin
          if (rollback) begin
            state_q <= ARB_IDLE;
          end else if (mc_ls_finish) begin
            state_q   <= ARB_IDLE;
            ld_data_q <= mc_ls_data;
            ld_resp_q <= 1'b1;
          end
        end
        ARB_WAIT_ST: begin
          if (mc_ls_finish) begin
            state_q   <= ARB_IDLE;
            st_resp_q <= 1'b1;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: table-driven grant checks plus directed sequences for timing, priority, starvation, rollback, rdy and reset.
module tb_mem_req_arbiter;
  logic         clk = 1'b0, rst = 1'b0, rdy = 1'b1, rollback = 1'b0;
  logic         if_req_valid = 1'b0, ld_req_valid = 1'b0, st_req_valid = 1'b0;
  logic [31:0]  if_req_pc = '0, ld_req_addr = '0, st_req_addr = '0, st_req_data = '0;
  logic [2:0]   ld_req_size = '0, st_req_size = '0;
  logic         if_req_ready, ld_req_ready, st_req_ready;
  logic         if_resp_valid, ld_resp_valid, st_resp_valid;
  logic [127:0] if_resp_block;
  logic [31:0]  ld_resp_data;
  logic         mc_fch_enable, mc_fch_rollback, mc_ls_enable, mc_ls_sign;
  logic [31:0]  mc_fch_pc, mc_ls_addr, mc_ls_store_data;
  logic [2:0]   mc_ls_size;
  logic         mc_fch_finish, mc_ls_finish;
  logic [127:0] m_fch_block = '0;
  logic [31:0]  m_ls_data = '0;
  logic         auto_mc = 1'b0, m_fch_fin = 1'b0, m_ls_fin = 1'b0, a_fch_fin = 1'b0, a_ls_fin = 1'b0;
  int           total = 0, pass = 0;
  typedef struct {
    logic rdy, rb, ifv, ldv, stv;
    logic [3:0] exp;
  } vec_t;
  vec_t vt[10];
  always #5 clk = ~clk;
  assign mc_fch_finish = auto_mc ? a_fch_fin : m_fch_fin;
  assign mc_ls_finish  = auto_mc ? a_ls_fin : m_ls_fin;
  // MemCtrl model: completes each request in the same cycle its enable is seen.
  always @(negedge clk) begin
    a_ls_fin  = mc_ls_enable;
    a_fch_fin = mc_fch_enable;
  end
  mem_req_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .if_req_valid(if_req_valid), .if_req_pc(if_req_pc), .if_req_ready(if_req_ready),
    .if_resp_valid(if_resp_valid), .if_resp_block(if_resp_block),
    .ld_req_valid(ld_req_valid), .ld_req_addr(ld_req_addr), .ld_req_size(ld_req_size), .ld_req_ready(ld_req_ready),
    .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data),
    .st_req_valid(st_req_valid), .st_req_addr(st_req_addr), .st_req_data(st_req_data), .st_req_size(st_req_size),
    .st_req_ready(st_req_ready), .st_resp_valid(st_resp_valid),
    .mc_fch_enable(mc_fch_enable), .mc_fch_pc(mc_fch_pc), .mc_fch_rollback(mc_fch_rollback),
    .mc_fch_finish(mc_fch_finish), .mc_fch_block(m_fch_block),
    .mc_ls_enable(mc_ls_enable), .mc_ls_sign(mc_ls_sign), .mc_ls_addr(mc_ls_addr), .mc_ls_size(mc_ls_size),
    .mc_ls_store_data(mc_ls_store_data), .mc_ls_finish(mc_ls_finish), .mc_ls_data(m_ls_data)
  );
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else pass++;
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    {rdy, rollback, if_req_valid, ld_req_valid, st_req_valid} = 5'b10000;
    {auto_mc, m_fch_fin, m_ls_fin} = 3'b000;
    cyc;
    rst = 1'b0;
    #1;
    rst = 1'b1;
  endtask
  initial begin
    int n, f, ls_cnt;
    int ord[3];
    int gaps[2];
    bit both, st_seen;
    logic [2:0] g;
    vt[0] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0000};
    vt[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0001};
    vt[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0010};
    vt[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0100};
    vt[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1001};
    vt[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1000};
    vt[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1000};
    vt[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
    vt[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0001};
    vt[9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1000};
    #2;
    chk("reset_outputs", {if_resp_valid, ld_resp_valid, st_resp_valid, mc_fch_enable, mc_ls_enable, mc_ls_sign},
        6'b0);
    chk("reset_data", {mc_fch_pc, mc_ls_addr, mc_ls_store_data, ld_resp_data}, 128'h0);
    chk("reset_block", if_resp_block, 128'h0);
    for (int i = 0; i < 10; i++) begin
      do_reset;
      {rdy, rollback, if_req_valid, ld_req_valid, st_req_valid} =
        {vt[i].rdy, vt[i].rb, vt[i].ifv, vt[i].ldv, vt[i].stv};
      #2;
      chk($sformatf("grant_vec%0d", i), {mc_fch_rollback, if_req_ready, ld_req_ready, st_req_ready}, vt[i].exp);
    end
    do_reset;
    ld_req_valid = 1'b1; ld_req_addr = 32'h1000; ld_req_size = 3'd4;
    #2 chk("ld_ready_T", ld_req_ready, 1'b1);
    cyc; ld_req_valid = 1'b0;
    #3 chk("ld_enable_T1", {mc_ls_enable, mc_ls_sign, mc_fch_enable, ld_req_ready}, 4'b1000);
    chk("ld_fields_T1", {mc_ls_addr, 29'h0, mc_ls_size}, {32'h1000, 32'd4});
    cyc; #3 chk("ld_enable_T2", mc_ls_enable, 1'b0);
    cyc; cyc; cyc;
    m_ls_fin = 1'b1; m_ls_data = 32'hDEADBEEF;
    #3 chk("ld_resp_T5", ld_resp_valid, 1'b0);
    cyc; m_ls_fin = 1'b0;
    #3 chk("ld_resp_T6", {ld_resp_valid, ld_resp_data}, {1'b1, 32'hDEADBEEF});
    cyc; #3 chk("ld_resp_T7", ld_resp_valid, 1'b0);
    do_reset;
    auto_mc = 1'b1;
    {if_req_valid, ld_req_valid, st_req_valid} = 3'b111;
    if_req_pc = 32'h0; ld_req_addr = 32'h1000; ld_req_size = 3'd4;
    st_req_addr = 32'h30000; st_req_data = 32'h41; st_req_size = 3'd1;
    n = 0; both = 0; st_seen = 0;
    for (int c = 0; c < 40 && n < 3; c++) begin
      #2;
      if (mc_fch_enable && mc_ls_enable) both = 1;
      if (mc_ls_enable && mc_ls_sign && !st_seen) begin
        st_seen = 1;
        chk("st_fields", {mc_ls_addr, mc_ls_store_data, 29'h0, mc_ls_size}, {32'h30000, 32'h41, 32'd1});
      end
      g = {if_req_ready, ld_req_ready, st_req_ready};
      if (g[0] && n < 3) ord[n++] = 1;
      if (g[1] && n < 3) ord[n++] = 2;
      if (g[2] && n < 3) ord[n++] = 3;
      cyc;
      if (g[0]) st_req_valid = 1'b0;
      if (g[1]) ld_req_valid = 1'b0;
      if (g[2]) if_req_valid = 1'b0;
    end
    chk("prio_count", n, 3);
    chk("prio_order", {ord[0][3:0], ord[1][3:0], ord[2][3:0]}, 12'h123);
    chk("prio_no_dual_enable", both, 1'b0);
    chk("prio_store_seen", st_seen, 1'b1);
    do_reset;
    auto_mc = 1'b1;
    {if_req_valid, ld_req_valid, st_req_valid} = 3'b111;
    f = 0; ls_cnt = 0;
    for (int c = 0; c < 300 && f < 2; c++) begin
      #2;
      if (ld_req_ready || st_req_ready) ls_cnt++;
      if (if_req_ready) begin
        gaps[f++] = ls_cnt;
        ls_cnt = 0;
      end
      cyc;
    end
    chk("starve_fetch_count", f, 2);
    chk("starve_gap_first", gaps[0], 8);
    chk("starve_gap_after_clear", gaps[1], 8);
    do_reset;
    ld_req_valid = 1'b1; ld_req_addr = 32'h2000; ld_req_size = 3'd2;
    #2 chk("rb_ld_ready", ld_req_ready, 1'b1);
    cyc; ld_req_valid = 1'b0;
    cyc; rollback = 1'b1;
    #3 chk("rb_fch_rollback", mc_fch_rollback, 1'b1);
    cyc; rollback = 1'b0; m_ls_fin = 1'b1; m_ls_data = 32'h5555; ld_req_valid = 1'b1;
    #3 chk("rb_idle_after", {ld_req_ready, ld_resp_valid}, 2'b10);
    cyc; m_ls_fin = 1'b0; ld_req_valid = 1'b0;
    #3 chk("rb_late_finish_dropped", ld_resp_valid, 1'b0);
    cyc; rollback = 1'b1; m_ls_fin = 1'b1;
    cyc; rollback = 1'b0; m_ls_fin = 1'b0;
    #3 chk("rb_same_cycle_finish_dropped", ld_resp_valid, 1'b0);
    do_reset;
    st_req_valid = 1'b1; st_req_addr = 32'h44; st_req_data = 32'h99; st_req_size = 3'd4;
    #2 chk("rbst_ready", st_req_ready, 1'b1);
    cyc; st_req_valid = 1'b0; rollback = 1'b1;
    cyc;
    cyc; m_ls_fin = 1'b1;
    #3 chk("rbst_no_early_resp", st_resp_valid, 1'b0);
    cyc; m_ls_fin = 1'b0; rollback = 1'b0;
    #3 chk("rbst_resp", st_resp_valid, 1'b1);
    do_reset;
    ld_req_valid = 1'b1; ld_req_addr = 32'h3000; ld_req_size = 3'd1;
    cyc; ld_req_valid = 1'b0; rdy = 1'b0;
    #3 chk("rdy_hold_enable1", mc_ls_enable, 1'b1);
    cyc; ld_req_valid = 1'b1;
    #3 chk("rdy_hold_enable2", {mc_ls_enable, ld_req_ready}, 2'b10);
    cyc; rdy = 1'b1; ld_req_valid = 1'b0;
    #3 chk("rdy_resume_enable", mc_ls_enable, 1'b1);
    cyc; #3 chk("rdy_enable_done", mc_ls_enable, 1'b0);
    do_reset;
    if_req_valid = 1'b1; if_req_pc = 32'h40;
    cyc; if_req_valid = 1'b0;
    #3 chk("rst_pre_fetch", {mc_fch_enable, mc_fch_pc}, {1'b1, 32'h40});
    rst = 1'b0;
    #1 chk("rst_async_zero", {mc_fch_enable, mc_fch_pc, if_resp_valid}, 34'h0);
    cyc; rst = 1'b1; m_fch_fin = 1'b1; m_fch_block = 128'h1234;
    #3 chk("rst_no_stale1", if_resp_valid, 1'b0);
    cyc; m_fch_fin = 1'b0;
    #3 chk("rst_no_stale2", if_resp_valid, 1'b0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
